// File: rtl/instruction_sequencer_pkg.sv
// seq_pkg: opcode values, sequencer states and instruction field positions
// shared by the instruction sequencer, its decoder and its issue interface.
package seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_SQA  = 4'h6;
    localparam logic [3:0] OP_SQB  = 4'h7;
    localparam logic [3:0] OP_PUSH = 4'h8;
    localparam logic [3:0] OP_LDA  = 4'h9;
    localparam logic [3:0] OP_LDB  = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_BSHL = 4'hC;
    localparam logic [3:0] OP_BSHR = 4'hD;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 4;
    localparam int RA_MSB = 3;
    localparam int RA_LSB = 2;
    localparam int RB_MSB = 1;
    localparam int RB_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } seq_state_e;

    // 4'hE and 4'hF are the only unassigned opcodes
    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op > OP_BSHR);
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Issue handshake bundle between the sequencer (master) and the datapath
// (slave): issue_valid/issue_ready plus the decoded op, ra and rb fields.
interface instruction_sequencer_if;

    logic       issue_valid;
    logic       issue_ready;
    logic [3:0] issue_op;
    logic [1:0] issue_ra;
    logic [1:0] issue_rb;

    modport master (
        output issue_valid,
        output issue_op,
        output issue_ra,
        output issue_rb,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_op,
        input  issue_ra,
        input  issue_rb,
        output issue_ready
    );

endinterface

// File: rtl/instruction_sequencer_decoder.sv
// seq_decoder: combinational split of an instruction byte.
// Ports: ir_i (instruction) -> op_o, ra_o, rb_o, is_out_o, is_illegal_o.
module seq_decoder
    import seq_pkg::*;
(
    input  logic [7:0] ir_i,
    output logic [3:0] op_o,
    output logic [1:0] ra_o,
    output logic [1:0] rb_o,
    output logic       is_out_o,
    output logic       is_illegal_o
);

    assign op_o         = ir_i[OP_MSB:OP_LSB];
    assign ra_o         = ir_i[RA_MSB:RA_LSB];
    assign rb_o         = ir_i[RB_MSB:RB_LSB];
    assign is_out_o     = (op_o == OP_OUT);
    assign is_illegal_o = op_is_illegal(op_o);

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches bytes from the program ROM, decodes them and
// issues ops through a valid/ready handshake until `out` or MAX_ADDR.
// Ports: clk, rst_n (async, active low); start/prog_sel begin a program;
//   rom_prog/rom_addr drive the ROM, rom_instr returns the byte;
//   issue (master modport) carries valid/ready/op/ra/rb;
//   busy (FETCH/ISSUE), done (normal halt), illegal (trapped halt).
// Build option: SEQ_ILLEGAL_TRAP_EN makes an illegal opcode halt with
//   `illegal` set; otherwise it is skipped as a silent NOP.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter logic [7:0] MAX_ADDR = 8'hFF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [1:0]                     prog_sel,
    output logic [1:0]                     rom_prog,
    output logic [7:0]                     rom_addr,
    input  logic [7:0]                     rom_instr,
    instruction_sequencer_if.master        issue,
    output logic                           busy,
    output logic                           done,
    output logic                           illegal
);

    seq_state_e state_q;
    logic [7:0] pc_q;
    logic [7:0] pc_d;
    logic [7:0] ir_q;
    logic [1:0] prog_q;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;
    logic       illegal_q;

    logic [3:0] dec_op;
    logic [1:0] dec_ra;
    logic [1:0] dec_rb;
    logic       dec_is_out;
    logic       dec_is_illegal;
    logic       at_max;
    logic       fetch_legal;

    seq_decoder u_dec (
        .ir_i         (ir_q),
        .op_o         (dec_op),
        .ra_o         (dec_ra),
        .rb_o         (dec_rb),
        .is_out_o     (dec_is_out),
        .is_illegal_o (dec_is_illegal)
    );

    assign pc_d   = pc_q + 8'd1;
    assign at_max = (pc_q == MAX_ADDR);

    // valid is registered, so legality of the incoming byte is judged
    // on the FETCH edge rather than from ir_q
    assign fetch_legal = !op_is_illegal(rom_instr[OP_MSB:OP_LSB]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= 8'h00;
            ir_q      <= 8'h00;
            prog_q    <= 2'b00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        prog_q    <= prog_sel;
                        pc_q      <= 8'h00;
                        done_q    <= 1'b0;
                        illegal_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir_q    <= rom_instr;
                    valid_q <= fetch_legal;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (dec_is_illegal) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                        illegal_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_HALT;
`else
                        if (at_max) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_HALT;
                        end else begin
                            pc_q    <= pc_d;
                            state_q <= S_FETCH;
                        end
`endif
                    end else if (issue.issue_ready) begin
                        valid_q <= 1'b0;
                        // PC never wraps: the last address halts even
                        // without an `out`
                        if (dec_is_out || at_max) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_HALT;
                        end else begin
                            pc_q    <= pc_d;
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_prog          = prog_q;
    assign rom_addr          = pc_q;
    assign issue.issue_valid = valid_q;
    assign issue.issue_op    = dec_op;
    assign issue.issue_ra    = dec_ra;
    assign issue.issue_rb    = dec_rb;
    assign busy              = busy_q;
    assign done              = done_q;
    assign illegal           = illegal_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Testbench for instruction_sequencer: decode table, hand-timed sequences
// and randomized programs checked against a behavioural program walker.
module tb_instruction_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, start3;
    logic [1:0] prog_sel, prog_sel3;
    logic [1:0] rom_prog, rom_prog3;
    logic [7:0] rom_addr, rom_addr3;
    logic [7:0] rom_instr, rom_instr3;
    logic       busy, done, illegal;
    logic       busy3, done3, illegal3;

    logic [7:0] rom_mem [4][256];

    assign rom_instr  = rom_mem[rom_prog][rom_addr];
    assign rom_instr3 = rom_mem[rom_prog3][rom_addr3];

    instruction_sequencer_if ifc ();
    instruction_sequencer_if ifc3 ();

    instruction_sequencer u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .prog_sel  (prog_sel),
        .rom_prog  (rom_prog),
        .rom_addr  (rom_addr),
        .rom_instr (rom_instr),
        .issue     (ifc),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    instruction_sequencer #(.MAX_ADDR(8'd3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start3),
        .prog_sel  (prog_sel3),
        .rom_prog  (rom_prog3),
        .rom_addr  (rom_addr3),
        .rom_instr (rom_instr3),
        .issue     (ifc3),
        .busy      (busy3),
        .done      (done3),
        .illegal   (illegal3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // observed handshakes: {address, instruction fields}
    logic [15:0] obs[$];
    logic [15:0] obs3[$];

    always @(posedge clk) begin
        if (rst_n && ifc.issue_valid && ifc.issue_ready)
            obs.push_back({rom_addr, ifc.issue_op, ifc.issue_ra, ifc.issue_rb});
        if (rst_n && ifc3.issue_valid && ifc3.issue_ready)
            obs3.push_back({rom_addr3, ifc3.issue_op, ifc3.issue_ra,
                            ifc3.issue_rb});
    end

    // reference: walk the program byte by byte
    logic [15:0] exp_q[$];
    bit          exp_done, exp_ill;
    logic [7:0]  exp_addr;

    task automatic model(input int p, input int max);
        logic [7:0] ins;
        exp_q.delete();
        exp_done = 0;
        exp_ill  = 0;
        exp_addr = 8'h00;
        for (int a = 0; a < 256; a++) begin
            ins      = rom_mem[p][a];
            exp_addr = a[7:0];
            if (ins >= 8'hE0) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                exp_ill = 1;
                break;
`endif
            end else begin
                exp_q.push_back({a[7:0], ins});
                if (ins[7:4] == 4'hB) begin
                    exp_done = 1;
                    break;
                end
            end
            if (a == max) begin
                exp_done = 1;
                break;
            end
        end
    endtask

    task automatic cmp_obs(input string name);
        chk({name, " count"}, 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk({name, " issue"},
                32'(i < obs.size() ? obs[i] : 16'hFFFF), 32'(exp_q[i]));
    endtask

    // returns at the negedge inside cycle 1 (FETCH of address 0)
    task automatic do_start(input logic [1:0] p);
        @(negedge clk);
        start    = 1'b1;
        prog_sel = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_check(input string name, input int p, input bit rnd);
        int cyc;
        bit fin;
        model(p, 255);
        obs.delete();
        ifc.issue_ready = 1'b1;
        do_start(p[1:0]);
        chk({name, " addr0"}, 32'(rom_addr), 32'h0);
        chk({name, " prog"}, 32'(rom_prog), 32'(p));
        cyc = 1;
        fin = 0;
        while (!fin && cyc < 3000) begin
            if (done || illegal) begin
                fin = 1;
            end else begin
                ifc.issue_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (rnd) begin
                    start    = 1'($urandom_range(0, 1));
                    prog_sel = 2'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        ifc.issue_ready = 1'b1;
        chk({name, " finished"}, 32'(fin), 32'h1);
        cmp_obs(name);
        chk({name, " done"}, 32'(done), 32'(exp_done));
        chk({name, " illegal"}, 32'(illegal), 32'(exp_ill));
        chk({name, " last addr"}, 32'(rom_addr), 32'(exp_addr));
        chk({name, " rom_prog"}, 32'(rom_prog), 32'(p));
    endtask

    typedef struct {
        logic [7:0] instr;
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        bit         legal;
    } vec_t;

    vec_t vecs[16];

    int c;

    initial begin
        vecs[0]  = '{8'h00, 4'h0, 2'd0, 2'd0, 1'b1};
        vecs[1]  = '{8'h1F, 4'h1, 2'd3, 2'd3, 1'b1};
        vecs[2]  = '{8'h2E, 4'h2, 2'd3, 2'd2, 1'b1};
        vecs[3]  = '{8'h37, 4'h3, 2'd1, 2'd3, 1'b1};
        vecs[4]  = '{8'h4B, 4'h4, 2'd2, 2'd3, 1'b1};
        vecs[5]  = '{8'h59, 4'h5, 2'd2, 2'd1, 1'b1};
        vecs[6]  = '{8'h66, 4'h6, 2'd1, 2'd2, 1'b1};
        vecs[7]  = '{8'h7D, 4'h7, 2'd3, 2'd1, 1'b1};
        vecs[8]  = '{8'h8C, 4'h8, 2'd3, 2'd0, 1'b1};
        vecs[9]  = '{8'h91, 4'h9, 2'd0, 2'd1, 1'b1};
        vecs[10] = '{8'hA6, 4'hA, 2'd1, 2'd2, 1'b1};
        vecs[11] = '{8'hB0, 4'hB, 2'd0, 2'd0, 1'b1};
        vecs[12] = '{8'hC6, 4'hC, 2'd1, 2'd2, 1'b1};
        vecs[13] = '{8'hD2, 4'hD, 2'd0, 2'd2, 1'b1};
        vecs[14] = '{8'hE4, 4'hE, 2'd1, 2'd0, 1'b0};
        vecs[15] = '{8'hF8, 4'hF, 2'd2, 2'd0, 1'b0};

        for (int p = 0; p < 4; p++)
            for (int a = 0; a < 256; a++)
                rom_mem[p][a] = 8'hB0;
        rom_mem[0][0] = 8'h90; rom_mem[0][1] = 8'hA4;
        rom_mem[0][2] = 8'h21; rom_mem[0][3] = 8'h80;
        rom_mem[0][4] = 8'h50; rom_mem[0][5] = 8'h80;
        rom_mem[0][6] = 8'h80; rom_mem[0][7] = 8'hB0;
        rom_mem[1][0] = 8'h90; rom_mem[1][1] = 8'hB0;
        rom_mem[2][0] = 8'h90; rom_mem[2][1] = 8'hE0;
        rom_mem[2][2] = 8'h21; rom_mem[2][3] = 8'hB0;
        for (int a = 0; a < 256; a++)
            rom_mem[3][a] = 8'(8'h10 + a[3:0]);

        rst_n = 1'b0;
        start = 1'b0;
        start3 = 1'b0;
        prog_sel = 2'b00;
        prog_sel3 = 2'b00;
        ifc.issue_ready = 1'b1;
        ifc3.issue_ready = 1'b1;

        // reset state
        #1;
        chk("rst valid", 32'(ifc.issue_valid), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst illegal", 32'(illegal), 32'h0);
        chk("rst addr", 32'(rom_addr), 32'h0);
        chk("rst prog", 32'(rom_prog), 32'h0);
        chk("rst op", 32'({ifc.issue_op, ifc.issue_ra, ifc.issue_rb}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // exact timing, program 01
        obs.delete();
        do_start(2'b01);
        for (c = 1; c <= 7; c++) begin
            chk("p1 valid", 32'(ifc.issue_valid), 32'(c == 2 || c == 4));
            chk("p1 done", 32'(done), 32'(c >= 5));
            chk("p1 busy", 32'(busy), 32'(c <= 4));
            if (c == 2) chk("p1 op0", 32'(ifc.issue_op), 32'h9);
            if (c == 4) chk("p1 op1", 32'(ifc.issue_op), 32'hB);
            @(negedge clk);
        end
        chk("p1 addr", 32'(rom_addr), 32'h1);

        // program 00, ready high: 8 issues, done in cycle 17
        model(0, 255);
        obs.delete();
        do_start(2'b00);
        c = 1;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("p0 done cycle", 32'(c), 32'd17);
        cmp_obs("p0");

        // stall on the 0xA4 issue for 3 cycles
        obs.delete();
        do_start(2'b00);
        c = 1;
        while (!done && c < 100) begin
            ifc.issue_ready = !(c >= 4 && c <= 6);
            if (c >= 4 && c <= 6) begin
                chk("stall valid", 32'(ifc.issue_valid), 32'h1);
                chk("stall fields",
                    32'({ifc.issue_op, ifc.issue_ra, ifc.issue_rb}), 32'hA4);
                chk("stall addr", 32'(rom_addr), 32'h1);
            end
            @(negedge clk);
            c++;
        end
        ifc.issue_ready = 1'b1;
        chk("stall done cycle", 32'(c), 32'd20);
        cmp_obs("stall");

        // illegal opcode at address 1
        run_check("illegal", 2, 0);
`ifdef SEQ_ILLEGAL_TRAP_EN
        chk("trap illegal", 32'(illegal), 32'h1);
        chk("trap done", 32'(done), 32'h0);
        chk("trap issues", 32'(obs.size()), 32'h1);
`else
        chk("nop issues", 32'(obs.size()), 32'h3);
        chk("nop next", 32'(obs.size() > 1 ? obs[1] : 16'hFFFF), 32'h0221);
`endif

        // decode table
        foreach (vecs[i]) begin
            rom_mem[1][0] = vecs[i].instr;
            rom_mem[1][1] = 8'hB0;
            run_check("tbl", 1, 0);
            if (vecs[i].legal) begin
                chk("tbl fields", 32'(obs.size() > 0 ? obs[0] : 16'hFFFF),
                    32'({8'h00, vecs[i].op, vecs[i].ra, vecs[i].rb}));
            end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                chk("tbl trap", 32'(illegal), 32'h1);
`else
                chk("tbl skip", 32'(obs.size() > 0 ? obs[0] : 16'hFFFF),
                    32'h01B0);
`endif
            end
        end

        // MAX_ADDR = 3, no out in program 11
        obs3.delete();
        @(negedge clk);
        start3 = 1'b1;
        prog_sel3 = 2'b11;
        @(negedge clk);
        start3 = 1'b0;
        c = 1;
        while (!done3 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("max done", 32'(done3), 32'h1);
        chk("max count", 32'(obs3.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("max issue", 32'(i < obs3.size() ? obs3[i] : 16'hFFFF),
                32'({i[7:0], rom_mem[3][i]}));
        repeat (4) @(negedge clk);
        chk("max no wrap addr", 32'(rom_addr3), 32'h3);
        chk("max no wrap count", 32'(obs3.size()), 32'd4);

        // reset during the ISSUE of address 2
        obs.delete();
        do_start(2'b00);
        for (c = 1; c < 6; c++) @(negedge clk);
        chk("mid valid", 32'(ifc.issue_valid), 32'h1);
        chk("mid addr", 32'(rom_addr), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", 32'(ifc.issue_valid), 32'h0);
        chk("mid rst busy", 32'(busy), 32'h0);
        chk("mid rst addr", 32'(rom_addr), 32'h0);
        chk("mid rst op", 32'({ifc.issue_op, ifc.issue_ra, ifc.issue_rb}),
            32'h0);
        chk("mid issues", 32'(obs.size()), 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("after rst", 3, 0);

        // randomized programs with random stalls and start/prog noise
        for (int r = 0; r < 20; r++) begin
            int p, pos;
            p = $urandom_range(0, 3);
            pos = $urandom_range(0, 30);
            for (int a = 0; a < 256; a++)
                rom_mem[p][a] = 8'($urandom);
            rom_mem[p][pos] = 8'hB0 | 8'($urandom_range(0, 15));
            run_check("rand", p, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Fetch/decode sequencer that reads the 8-bit instruction ROM for a selected program and issues decoded operations to the processor datapath. It drives `rom_prog`/`rom_addr`, registers the returned instruction, splits it into opcode and register fields, and presents each operation through a valid/ready handshake. It sits between the ROM and the ALU/register-file datapath and stops after the `out` instruction.

## Interface
- `MAX_ADDR`, default 8'hFF: last fetchable address. Reaching it without `out` forces a halt.
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin a program; sampled only in IDLE or HALT
- `prog_sel`  in  2  program number, latched on accepted `start`
- `rom_prog`  out  2  program select to ROM; reset 2'b00
- `rom_addr`  out  8  ROM address, equals PC; reset 8'h00
- `rom_instr`  in  8  ROM instruction, combinational from `rom_prog`/`rom_addr`
- `issue_valid`  out  1  decoded operation present; reset 0
- `issue_ready`  in  1  datapath accepts the operation
- `issue_op`  out  4  opcode `ir[7:4]`; reset 0
- `issue_ra`  out  2  first register `ir[3:2]`; reset 0
- `issue_rb`  out  2  second register `ir[1:0]`; reset 0
- `busy`  out  1  state is FETCH or ISSUE; reset 0
- `done`  out  1  HALT reached normally; reset 0
- `illegal`  out  1  halted on an illegal opcode; reset 0

## Operation
- Opcodes: add 0000, sub 0001, mul 0010, div 0011, shl 0100, shr 0101, sqa 0110, sqb 0111, push 1000, lda 1001, ldb 1010, out 1011, bshl 1100, bshr 1101. Values 1110 and 1111 are illegal.
- IDLE:
  - `start` latches `prog_sel` into `rom_prog`, clears PC, `done` and `illegal`.
  - Next state FETCH.
- FETCH:
  - `rom_addr` = PC for one full cycle.
  - At the end of the cycle, `ir` <= `rom_instr`.
  - Next state ISSUE.
- ISSUE, legal opcode:
  - `issue_valid` = 1.
  - `issue_op`, `issue_ra`, `issue_rb` stay stable until the cycle `issue_ready` = 1 (handshake at that edge).
  - On handshake with opcode `out`: next state HALT, `done` <= 1.
  - On handshake with PC == MAX_ADDR: next state HALT, `done` <= 1. PC never wraps.
  - On any other handshake: PC <= PC+1, next state FETCH.
- ISSUE, illegal opcode: behaviour is set by the macro described under Configuration.
- HALT:
  - `done` or `illegal` stays high.
  - Outputs hold their last values.
  - `start` restarts exactly as from IDLE.
- `start` while `busy` is ignored; `prog_sel` changes during a run are ignored.
- Reset mid-run returns immediately to IDLE: PC = 0, `ir` = 0, all outputs at their reset values, no partial issue.

## Timing
- `start` sampled at edge 0 → FETCH in cycle 1 → first `issue_valid` in cycle 2.
- With `issue_ready` tied high, each instruction takes 2 cycles (FETCH + ISSUE).
- Each stalled cycle (`issue_ready` = 0) adds 1 cycle. No fetch runs ahead of an unaccepted issue.
- `done` rises the cycle after the handshake of `out`.
- `issue_valid` is registered with no combinational path from `issue_ready`.
- `rom_addr` changes only on the edge that leaves ISSUE or on an accepted `start`.

## Configuration
- `SEQ_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in ISSUE does not assert `issue_valid`.
  - It sets `illegal` = 1 and goes to HALT on the next edge. `done` stays 0.
- `SEQ_ILLEGAL_TRAP_EN` undefined:
  - An illegal opcode is a silent NOP: no `issue_valid`, PC+1, back to FETCH.
  - The MAX_ADDR halt still applies. `illegal` stays 0.

## Structure
- Package `seq_pkg` holds:
  - the 4-bit opcode localparams listed above;
  - the state enum IDLE/FETCH/ISSUE/HALT;
  - the field slice positions (opcode [7:4], ra [3:2], rb [1:0]).
- One combinational sub-module, `seq_decoder`: takes `ir`, returns `op`, `ra`, `rb`, `is_out`, `is_illegal`.
- PC, `ir` and the FSM live in `instruction_sequencer`.

## Test plan
- Program 01, bench ROM {0x90, 0xB0}, `issue_ready` = 1, `start` at cycle 0 → issues 0x9/00/00 in cycle 2 and 0xB/00/00 in cycle 4; `done` = 1 from cycle 5; `rom_addr` ends at 1.
- Program 00, ROM {0x90, 0xA4, 0x21, 0x80, 0x50, 0x80, 0x80, 0xB0} → 8 issues in order; ops 9, A, 2, 8, 5, 8, 8, B; `ra`/`rb` match the low fields; `done` after 16 cycles.
- Stall: hold `issue_ready` = 0 for 3 cycles on the 0xA4 issue → op, `ra` = 01 and `rb` = 00 stay stable; `rom_addr` stays 1; the run finishes 3 cycles later.
- Illegal 0xE0 at address 1:
  - With the trap macro: `illegal` = 1, `done` = 0, no issue of 0xE.
  - Without it: 0xE0 is skipped and the next instruction issues from address 2.
- `MAX_ADDR` = 3 with no `out` in the ROM → exactly 4 issues, then `done` = 1, `rom_addr` = 3, no wrap.
- `rst_n` low during the ISSUE of address 2 → `issue_valid`, `busy` = 0 immediately; a later `start` with `prog_sel` = 11 fetches from address 0 of program 11.
